rtr_pkt_tx: RTL and testbench
=============================

Name: rtr_pkt_tx

Overview:
- Packet transmitter for the serial router input: accepts parallel (address, payload) requests and serializes each into the router's bit stream.
- Drives the router's `in` bit from `ser_out` and its `rx_ready` qualifier from `ser_valid`.
- A small request FIFO decouples the producer; a programmable idle gap separates packets.
- Sits upstream of the router: test stimulus generator and real source of traffic to the four destinations.

Parameters:
- ADDR_W, 2, destination address width in bits (selects 1 of 2^ADDR_W outputs).
- DATA_W, 4, payload width in bits.
- GAP, 1, idle cycles (ser_valid=0) forced after each packet; 0 allowed.
- FIFO_DEPTH, 2, request FIFO entries; power of two, at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  producer offers a request.
- req_ready  output  1  FIFO can accept (not full).
- req_addr  input  ADDR_W  destination address.
- req_data  input  DATA_W  payload.
- ser_out  output  1  serial bit to router `in`.
- ser_valid  output  1  bit qualifier to router `rx_ready`.
- busy  output  1  high when state is not IDLE or the FIFO is non-empty.
- pkt_cnt  output  8  packets fully transmitted, wraps 255->0.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; state IDLE.
  - ser_out=0, ser_valid=0, busy=0, pkt_cnt=0.
  - req_ready=1 as soon as reset releases.
- Push: on a clk edge with req_valid&req_ready, {req_addr,req_data} is written to the FIFO tail. req_ready is registered-free, i.e. combinational !full.
- Packet frame: ADDR_W address bits MSB first, then DATA_W payload bits MSB first. ser_valid is high for exactly ADDR_W+DATA_W consecutive cycles per packet, with no holes.
- All outputs are registered. ser_out=0 whenever ser_valid=0.
- States:
  - IDLE: if FIFO non-empty at an edge, pop head into the shift register and go to ADDR. ser_valid rises after that same edge.
  - ADDR: output addr[ADDR_W-1-i] for i=0..ADDR_W-1, then go to DATA.
  - DATA: output data[DATA_W-1-j] for j=0..DATA_W-1.
    - At the edge ending the last bit, pkt_cnt increments.
    - Then go to GAP if GAP>0.
    - If GAP=0: pop the next entry if the FIFO is non-empty and go straight to ADDR (back-to-back); otherwise go to IDLE.
  - GAP: ser_valid=0 for exactly GAP cycles, then behave as IDLE at the next edge.
- Latency: request pushed at edge N into an empty FIFO while IDLE -> popped at edge N+1 -> first address bit valid in cycle after edge N+1 -> last payload bit in cycle after edge N+ADDR_W+DATA_W.
- FIFO full: req_ready=0 and pushes are ignored. Push and pop on the same edge are allowed when not full; count is unchanged.
- FIFO wrap-around: pointers wrap modulo FIFO_DEPTH; order is strictly preserved.
- Reset mid-packet:
  - Frame aborted immediately; ser_valid drops asynchronously.
  - Partial packet not counted; FIFO contents discarded.
- Inputs req_addr/req_data are sampled only on a push edge and may change freely otherwise.

Test Plan:
- Reset then single request addr=2'b10, data=4'b0110 pushed at edge N:
  - ser_valid high for 6 cycles starting after edge N+1.
  - ser_out sequence 1,0,0,1,1,0; then ser_valid=0.
  - pkt_cnt=1 and busy=0 after GAP.
- GAP=1, two requests pushed on consecutive edges (addr=0,data=4'hF; addr=3,data=4'h1):
  - Bits 0,0,1,1,1,1, then exactly one cycle ser_valid=0, then 1,1,0,0,0,1.
  - pkt_cnt=2.
- GAP=0, three back-to-back requests:
  - ser_valid continuously high for 18 cycles; bit order matches pushes.
  - req_ready goes low when the FIFO holds 2 and an extra push is dropped.
- Hold req_valid=1 with data incrementing each edge:
  - Accepted sequence equals transmitted sequence, proving no loss or duplication across pointer wrap.
  - At least 8 packets transmitted.
- Assert rst=0 during the 3rd bit of a packet:
  - ser_valid and ser_out are 0 before the next edge; pkt_cnt=0.
  - After release, a fresh request transmits cleanly.
- Transmit 256 packets: pkt_cnt wraps to 0 after the 256th last-bit edge.

Source files
------------

// File: rtl/rtr_pkt_tx.sv
// Packet transmitter feeding the serial router: queues (address, payload) requests
// and shifts each out MSB first on ser_out, qualified by ser_valid, with an idle gap between packets.
module rtr_pkt_tx #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 4,
    parameter int GAP        = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic [7:0]        pkt_cnt
);

    localparam int FRM_W = ADDR_W + DATA_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = (FRM_W > 1) ? $clog2(FRM_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [GAP_W-1:0] GAP_LD    = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRM_W - 1);
    localparam logic [BIT_W-1:0] LAST_ADDR = BIT_W'(ADDR_W - 1);
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    logic [FRM_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    logic [FRM_W-1:0] r_shift;
    logic [BIT_W-1:0] r_bit_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_busy;
    logic [7:0]       r_pkt_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_done;
    logic             w_gap_ld;
    logic [FRM_W-1:0] w_head;
    logic [CNT_W-1:0] w_count_nxt;
    state_t           w_state_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_MAX) ? '0 : (p + PTR_W'(1));
    endfunction

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign req_ready = !w_full;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign busy      = r_busy;
    assign pkt_cnt   = r_pkt_cnt;

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Request FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {req_addr, req_data};
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, FIFO pop and end-of-packet decode
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_gap_ld    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (r_bit_idx == LAST_ADDR) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_bit_idx == LAST_BIT) begin
                    w_done = 1'b1;
                    if (GAP > 0) begin
                        w_gap_ld    = 1'b1;
                        w_state_nxt = ST_GAP;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_GAP: begin
                // Final gap cycle acts exactly like IDLE
                if (r_gap_cnt != '0) begin
                    w_state_nxt = ST_GAP;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register and registered serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else if (w_pop) begin
            r_shift     <= {w_head[FRM_W-2:0], 1'b0};
            r_bit_idx   <= '0;
            r_ser_out   <= w_head[FRM_W-1];
            r_ser_valid <= 1'b1;
        end else if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !w_done) begin
            r_shift     <= {r_shift[FRM_W-2:0], 1'b0};
            r_bit_idx   <= r_bit_idx + BIT_W'(1);
            r_ser_out   <= r_shift[FRM_W-1];
            r_ser_valid <= 1'b1;
        end else begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end
    end

    // Inter-packet gap countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= '0;
        end else if (w_gap_ld) begin
            r_gap_cnt <= GAP_LD;
        end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end

    // Packet counter and busy flag, both computed from post-edge state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_cnt <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            if (w_done) begin
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end
            r_busy <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_rtr_pkt_tx.sv
// Scoreboard bench for rtr_pkt_tx: one instance with GAP=1 and one with GAP=0.
module tb_rtr_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rv1, rdy1, so1, sv1, busy1;
    logic [1:0] ra1;
    logic [3:0] rd1;
    logic [7:0] pc1;
    logic       rv0, rdy0, so0, sv0, busy0;
    logic [1:0] ra0;
    logic [3:0] rd0;
    logic [7:0] pc0;

    int   n_chk = 0;
    int   n_err = 0;
    logic q1[$];
    logic q0[$];
    int   acc1 = 0;
    int   acc0 = 0;
    int   run1 = 0;
    int   run0 = 0;
    logic [5:0] f1, f0;

    always #5 clk = ~clk;

    rtr_pkt_tx #(.ADDR_W(2), .DATA_W(4), .GAP(1), .FIFO_DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_addr(ra1), .req_data(rd1),
        .ser_out(so1), .ser_valid(sv1), .busy(busy1), .pkt_cnt(pc1)
    );

    rtr_pkt_tx #(.ADDR_W(2), .DATA_W(4), .GAP(0), .FIFO_DEPTH(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_addr(ra0), .req_data(rd0),
        .ser_out(so0), .ser_valid(sv0), .busy(busy0), .pkt_cnt(pc0)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: ser_valid high with no expected bit (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int which);
        int t;
        t = 0;
        while (((which == 1) ? (busy1 | sv1) : (busy0 | sv0)) && t < 300) begin
            step();
            t++;
        end
        chk((which == 1) ? "u1_drain_timeout" : "u0_drain_timeout", int'(t < 300), 1);
        chk((which == 1) ? "u1_queue_left" : "u0_queue_left", (which == 1) ? q1.size() : q0.size(), 0);
    endtask

    // Scoreboard push: every accepted request queues its six frame bits
    always @(posedge clk) begin
        if (rst && rv1 && rdy1) begin
            f1 = {ra1, rd1};
            for (int i = 5; i >= 0; i--) q1.push_back(f1[i]);
            acc1++;
        end
        if (rst && rv0 && rdy0) begin
            f0 = {ra0, rd0};
            for (int i = 5; i >= 0; i--) q0.push_back(f0[i]);
            acc0++;
        end
    end

    // Monitor: compare serial bits, frame lengths and idle output
    always @(negedge clk) begin
        if (!rst) begin
            run1 = 0;
            run0 = 0;
        end else begin
            if (sv1) begin
                if (q1.size() == 0) fail_now("u1_spurious_bit");
                else chk("u1_bit", int'(so1), int'(q1.pop_front()));
                run1++;
            end else begin
                chk("u1_idle_out", int'(so1), 0);
                if (run1 != 0) begin
                    chk("u1_frame_len", run1, 6);
                    run1 = 0;
                end
            end
            if (sv0) begin
                if (q0.size() == 0) fail_now("u0_spurious_bit");
                else chk("u0_bit", int'(so0), int'(q0.pop_front()));
                run0++;
            end else begin
                chk("u0_idle_out", int'(so0), 0);
                if (run0 != 0) begin
                    chk("u0_frame_len_mod6", run0 % 6, 0);
                    run0 = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  exp1;
        logic [12:0] exp_v, exp_o;
        int          k, t, base, pc_before;

        rst = 1'b0;
        rv1 = 1'b0; ra1 = 2'd0; rd1 = 4'd0;
        rv0 = 1'b0; ra0 = 2'd0; rd0 = 4'd0;
        repeat (3) step();
        chk("rst_ser_valid", int'(sv1), 0);
        chk("rst_ser_out", int'(so1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_pkt_cnt", int'(pc1), 0);
        rst = 1'b1;
        chk("rst_req_ready", int'(rdy1), 1);

        // Single request addr=10 data=0110 -> 1,0,0,1,1,0
        exp1 = 6'b100110;
        rv1 = 1'b1; ra1 = 2'b10; rd1 = 4'b0110;
        step();
        rv1 = 1'b0;
        chk("t1_valid_before_pop", int'(sv1), 0);
        chk("t1_busy_queued", int'(busy1), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t1_valid", int'(sv1), 1);
            chk("t1_bit", int'(so1), int'(exp1[5-i]));
        end
        step();
        chk("t1_valid_end", int'(sv1), 0);
        chk("t1_pkt_cnt", int'(pc1), 1);
        chk("t1_busy_gap", int'(busy1), 1);
        step();
        chk("t1_busy_after_gap", int'(busy1), 0);
        chk("t1_pkt_cnt_after_gap", int'(pc1), 1);

        // GAP=1, two consecutive pushes
        exp_v = 13'b1111110111111;
        exp_o = 13'b0011110110001;
        rv1 = 1'b1; ra1 = 2'd0; rd1 = 4'hF;
        step();
        chk("t2_valid_before_pop", int'(sv1), 0);
        ra1 = 2'd3; rd1 = 4'h1;
        step();
        rv1 = 1'b0;
        for (int c = 0; c < 13; c++) begin
            chk("t2_valid_seq", int'(sv1), int'(exp_v[12-c]));
            chk("t2_out_seq", int'(so1), int'(exp_o[12-c]));
            step();
        end
        chk("t2_valid_end", int'(sv1), 0);
        drain(1);
        chk("t2_pkt_cnt", int'(pc1), 3);

        // GAP=0, back-to-back frames and a push dropped when full
        rv0 = 1'b1; ra0 = 2'd1; rd0 = 4'h5;
        chk("t3_ready_0", int'(rdy0), 1);
        step();
        chk("t3_valid_before_pop", int'(sv0), 0);
        ra0 = 2'd2; rd0 = 4'hA;
        chk("t3_ready_1", int'(rdy0), 1);
        step();
        chk("t3_valid_c1", int'(sv0), 1);
        ra0 = 2'd3; rd0 = 4'hC;
        chk("t3_ready_2", int'(rdy0), 1);
        step();
        chk("t3_valid_c2", int'(sv0), 1);
        ra0 = 2'd0; rd0 = 4'h3;
        chk("t3_ready_full", int'(rdy0), 0);
        step();
        rv0 = 1'b0;
        for (int c = 3; c <= 18; c++) begin
            chk("t3_valid_cont", int'(sv0), 1);
            step();
        end
        chk("t3_valid_end", int'(sv0), 0);
        drain(0);
        chk("t3_pkt_cnt", int'(pc0), 3);
        chk("t3_accepted", acc0, 3);

        // Continuous offers with incrementing payload across pointer wrap
        pc_before = int'(pc1);
        base = acc1;
        k = 0;
        rv1 = 1'b1;
        for (int c = 0; c < 80; c++) begin
            ra1 = k[5:4];
            rd1 = k[3:0];
            step();
            k++;
        end
        rv1 = 1'b0;
        drain(1);
        chk("t4_pkt_cnt", int'(pc1), (pc_before + acc1 - base) & 255);
        chk("t4_at_least_8", int'((int'(pc1) - pc_before) >= 8), 1);

        // Reset during the third bit of a frame
        rv1 = 1'b1; ra1 = 2'd1; rd1 = 4'h9;
        step();
        rv1 = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        chk("t5_valid_async", int'(sv1), 0);
        chk("t5_out_async", int'(so1), 0);
        chk("t5_pkt_cnt", int'(pc1), 0);
        chk("t5_pkt_cnt_u0", int'(pc0), 0);
        q1.delete();
        q0.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", int'(rdy1), 1);
        chk("t5_busy_after", int'(busy1), 0);
        rv1 = 1'b1; ra1 = 2'd2; rd1 = 4'h3;
        step();
        rv1 = 1'b0;
        drain(1);
        chk("t5_fresh_pkt_cnt", int'(pc1), 1);

        // 256 frames on the GAP=0 instance: counter wraps to 0
        base = acc0;
        k = 0;
        t = 0;
        rv0 = 1'b1;
        while ((acc0 - base) < 255 && t < 4000) begin
            ra0 = k[5:4];
            rd0 = k[3:0];
            step();
            k++;
            t++;
        end
        rv0 = 1'b0;
        chk("t6_push_timeout", int'(t < 4000), 1);
        drain(0);
        chk("t6_pkt_cnt_255", int'(pc0), 255);
        rv0 = 1'b1; ra0 = 2'd3; rd0 = 4'h7;
        step();
        rv0 = 1'b0;
        drain(0);
        chk("t6_pkt_cnt_wrap", int'(pc0), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
